// File: rtl/decode_stage_pipelined.sv
// Instruction decode stage: register file with write-through bypass, branch/jump
// resolution, load-use hazard detection and a registered ID/EX pipeline register.
module decode_stage_pipelined #(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int CTRL_W      = 16,
   parameter int MEMREAD_BIT = 3,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   if_valid,
   input  logic [31:0]            instr_in,
   input  logic [DATA_W-1:0]      pc_in,
   input  logic [CTRL_W-1:0]      ctrl_in,
   input  logic [2:0]             br_type,
   input  logic                   wb_we,
   input  logic [REG_ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic                   ex_hold,
   input  logic                   flush_in,
   output logic                   if_stall,
   output logic                   redirect_valid,
   output logic [DATA_W-1:0]      redirect_pc,
   output logic                   ex_valid,
   output logic [CTRL_W-1:0]      ex_ctrl,
   output logic [DATA_W-1:0]      ex_pc,
   output logic [DATA_W-1:0]      ex_rs_data,
   output logic [DATA_W-1:0]      ex_rt_data,
   output logic [DATA_W-1:0]      ex_imm,
   output logic [REG_ADDR_W-1:0]  ex_rs,
   output logic [REG_ADDR_W-1:0]  ex_rt,
   output logic [REG_ADDR_W-1:0]  ex_rd,
   output logic [4:0]             ex_shamt,
   output logic [5:0]             ex_funct,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0]     reg_file [NUM_REGS];
   logic [REG_ADDR_W-1:0] rs, rt, rd;
   logic [DATA_W-1:0]     rs_data, rt_data;
   logic [DATA_W-1:0]     imm_ext;
   logic [DATA_W-1:0]     branch_target, jump_target;
   logic                  hazard;
   logic                  cond_true;
   logic                  unused_opcode;

   assign rs            = REG_ADDR_W'(instr_in[25:21]);
   assign rt            = REG_ADDR_W'(instr_in[20:16]);
   assign rd            = REG_ADDR_W'(instr_in[15:11]);
   assign imm_ext       = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
   assign unused_opcode = ^instr_in[31:26];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_file[i] <= '0;
         end
      end else if (wb_we && wb_addr != '0) begin
         reg_file[wb_addr] <= wb_data;
      end
   end

   // Reads see a same-cycle writeback so the new value reaches ID/EX without a stall.
   always_comb begin
      rs_data = '0;
      if (rs != '0) begin
         rs_data = (wb_we && wb_addr == rs) ? wb_data : reg_file[rs];
      end
   end

   always_comb begin
      rt_data = '0;
      if (rt != '0) begin
         rt_data = (wb_we && wb_addr == rt) ? wb_data : reg_file[rt];
      end
   end

   // Conservative: an rt match stalls even if the instruction never reads rt.
   assign hazard = if_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != '0) &
                   ((ex_rt == rs) | (ex_rt == rt));
   assign if_stall = hazard | ex_hold;

   always_comb begin
      cond_true = 1'b0;
      case (br_type)
         3'd1:    cond_true = (rs_data == rt_data);
         3'd2:    cond_true = (rs_data != rt_data);
         3'd3:    cond_true = ($signed(rs_data) < $signed(rt_data));
         3'd4:    cond_true = ($signed(rs_data) > $signed(rt_data));
         3'd5:    cond_true = rs_data[DATA_W-1];
         3'd6:    cond_true = !rs_data[DATA_W-1] && (rs_data != '0);
         3'd7:    cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   assign branch_target  = pc_in + {imm_ext[DATA_W-3:0], 2'b00};
   assign jump_target    = {pc_in[DATA_W-1:28], instr_in[25:0], 2'b00};
   assign redirect_pc    = (br_type == 3'd7) ? jump_target : branch_target;
   assign redirect_valid = if_valid & !if_stall & !flush_in & cond_true;

   // Hold beats flush: a flush arriving under ex_hold is dropped here.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_pc      <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_shamt   <= '0;
         ex_funct   <= '0;
      end else if (!ex_hold) begin
         if (flush_in || hazard || !if_valid) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
         end else begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= ctrl_in;
            ex_pc      <= pc_in;
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= imm_ext;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_shamt   <= instr_in[10:6];
            ex_funct   <= instr_in[5:0];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_count <= '0;
      end else if (hazard && !ex_hold && stall_count != '1) begin
         stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: directed scenarios plus randomized
// traffic compared against an instruction-level model of the decode stage.
module tb_decode_stage_pipelined;

   localparam int SCW     = 4;
   localparam int CNT_MAX = 15;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        if_valid;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic [15:0] ctrl_in;
   logic [2:0]  br_type;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_hold;
   logic        flush_in;
   logic        if_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ex_valid;
   logic [15:0] ex_ctrl;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [5:0]  ex_funct;
   logic [SCW-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [15:0] m_ctrl;
   logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
   logic [5:0]  m_funct;
   int          m_cnt;

   logic        last_stall, last_redir_valid;
   logic [31:0] last_redir_pc;
   logic [31:0] snap_pc, snap_rsd;

   decode_stage_pipelined #(.STALL_CNT_W(SCW)) dut (
      .Clk(Clk), .Reset(Reset), .if_valid(if_valid), .instr_in(instr_in),
      .pc_in(pc_in), .ctrl_in(ctrl_in), .br_type(br_type), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data), .ex_hold(ex_hold), .flush_in(flush_in),
      .if_stall(if_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_funct(ex_funct), .stall_count(stall_count)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] modelRead(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_shamt = '0; m_funct = '0; m_cnt = 0;
   endtask

   task automatic checkRegistered(input string tag);
      checkOutput({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
      checkOutput({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ctrl));
      checkOutput({tag, ".stall_count"}, 64'(stall_count), 64'(m_cnt));
      if (m_valid) begin
         checkOutput({tag, ".ex_pc"}, 64'(ex_pc), 64'(m_pc));
         checkOutput({tag, ".ex_rs_data"}, 64'(ex_rs_data), 64'(m_rsd));
         checkOutput({tag, ".ex_rt_data"}, 64'(ex_rt_data), 64'(m_rtd));
         checkOutput({tag, ".ex_imm"}, 64'(ex_imm), 64'(m_imm));
         checkOutput({tag, ".ex_regs"}, {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, m_rs, m_rt, m_rd});
         checkOutput({tag, ".ex_shfn"}, {53'd0, ex_shamt, ex_funct}, {53'd0, m_shamt, m_funct});
      end
   endtask

   // One decode cycle: drive, check decode-time outputs, clock, check ID/EX.
   task automatic applyStimulus(input string tag, input logic iv, input logic [31:0] instr,
                                input logic [31:0] pc, input logic [15:0] ctrl,
                                input logic [2:0] br, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic hold, input logic flush);
      logic [4:0]  rs, rt;
      logic [31:0] rsv, rtv, tgt;
      logic        haz, stall, cond, redir;
      int          offset;
      if_valid = iv; instr_in = instr; pc_in = pc; ctrl_in = ctrl; br_type = br;
      wb_we = we; wb_addr = wa; wb_data = wd; ex_hold = hold; flush_in = flush;
      #1;
      rs  = instr[25:21];
      rt  = instr[20:16];
      rsv = modelRead(rs);
      rtv = modelRead(rt);
      haz = iv && m_valid && m_ctrl[3] && m_rt != 0 && (m_rt == rs || m_rt == rt);
      stall = haz || hold;
      case (br)
         3'd1:    cond = (rsv == rtv);
         3'd2:    cond = (rsv != rtv);
         3'd3:    cond = ($signed(rsv) < $signed(rtv));
         3'd4:    cond = ($signed(rsv) > $signed(rtv));
         3'd5:    cond = ($signed(rsv) < 0);
         3'd6:    cond = ($signed(rsv) > 0);
         3'd7:    cond = 1'b1;
         default: cond = 1'b0;
      endcase
      offset = $signed(instr[15:0]);
      if (br == 3'd7) tgt = (pc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
      else            tgt = pc + 32'(offset * 4);
      redir = iv && !stall && !flush && cond;
      last_stall       = if_stall;
      last_redir_valid = redirect_valid;
      last_redir_pc    = redirect_pc;
      checkOutput({tag, ".if_stall"}, 64'(if_stall), 64'(stall));
      checkOutput({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(redir));
      if (redir) checkOutput({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(tgt));
      @(posedge Clk);
      if (we && wa != 0) m_regs[wa] = wd;
      if (haz && !hold && m_cnt < CNT_MAX) m_cnt++;
      if (!hold) begin
         if (flush || haz || !iv) begin
            m_valid = 1'b0;
            m_ctrl  = '0;
         end else begin
            m_valid = 1'b1; m_ctrl = ctrl; m_pc = pc; m_rsd = rsv; m_rtd = rtv;
            m_imm = 32'(offset); m_rs = rs; m_rt = rt; m_rd = instr[15:11];
            m_shamt = instr[10:6]; m_funct = instr[5:0];
         end
      end
      #1;
      checkRegistered(tag);
   endtask

   task automatic idle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
      applyStimulus(tag, 1'b0, 32'd0, 32'd0, 16'd0, 3'd0, we, wa, wd, 1'b0, 1'b0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic resetPulse(input string tag);
      #1 Reset = 1'b1;
      #1;
      checkOutput({tag, ".ex_valid"}, 64'(ex_valid), 64'd0);
      checkOutput({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'd0);
      checkOutput({tag, ".ex_data"}, {ex_pc, ex_rs_data} | {ex_rt_data, ex_imm}, 64'd0);
      checkOutput({tag, ".ex_fields"}, {42'd0, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct}, 64'd0);
      checkOutput({tag, ".stall_count"}, 64'(stall_count), 64'd0);
      checkOutput({tag, ".if_stall"}, 64'(if_stall), 64'(ex_hold));
      modelReset();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; if_valid = 0; instr_in = 0; pc_in = 0; ctrl_in = 0; br_type = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; ex_hold = 0; flush_in = 0;
      modelReset();
      #12;
      checkOutput("reset.ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("reset.stall_count", 64'(stall_count), 64'd0);
      checkOutput("reset.redirect_valid", 64'(redirect_valid), 64'd0);
      Reset = 1'b0;

      idle("wr_r5", 1'b1, 5'd5, 32'h0000_1234);
      applyStimulus("add_r5", 1, rtype(5, 0, 3), 32'h8, 16'h0001, 0, 0, 0, 0, 0, 0);
      checkOutput("tp_r5_rs", 64'(ex_rs_data), 64'h1234);
      checkOutput("tp_r5_rt", 64'(ex_rt_data), 64'h0);
      checkOutput("tp_r5_valid", 64'(ex_valid), 64'h1);

      applyStimulus("byp_r7", 1, rtype(7, 0, 4), 32'hC, 16'h0001, 0, 1, 7, 32'hDEAD_BEEF, 0, 0);
      checkOutput("tp_bypass", 64'(ex_rs_data), 64'hDEAD_BEEF);
      idle("wr_r0", 1'b1, 5'd0, 32'hFFFF_FFFF);
      applyStimulus("rd_r0", 1, rtype(0, 0, 1), 32'h10, 16'h0001, 0, 0, 0, 0, 0, 0);
      checkOutput("tp_r0", 64'(ex_rs_data), 64'h0);

      applyStimulus("lw_r8", 1, itype(6'h23, 0, 8, 16'h4), 32'h14, 16'h0009, 0, 0, 0, 0, 0, 0);
      applyStimulus("use_r8", 1, rtype(8, 0, 2), 32'h18, 16'h0001, 0, 0, 0, 0, 0, 0);
      checkOutput("tp_lu_stall", 64'(last_stall), 64'h1);
      checkOutput("tp_lu_bubble", 64'(ex_valid), 64'h0);
      checkOutput("tp_lu_cnt", 64'(stall_count), 64'h1);
      applyStimulus("use_r8_go", 1, rtype(8, 0, 2), 32'h18, 16'h0001, 0, 0, 0, 0, 0, 0);
      checkOutput("tp_lu_load", 64'(ex_valid), 64'h1);

      idle("wr_r1", 1'b1, 5'd1, 32'd3);
      idle("wr_r2", 1'b1, 5'd2, 32'd3);
      applyStimulus("beq", 1, itype(6'h04, 1, 2, 16'hFFFF), 32'h100, 16'h0002, 1, 0, 0, 0, 0, 0);
      checkOutput("tp_beq_valid", 64'(last_redir_valid), 64'h1);
      checkOutput("tp_beq_pc", 64'(last_redir_pc), 64'hFC);

      idle("wr_r1m", 1'b1, 5'd1, 32'hFFFF_FFFF);
      idle("wr_r2p", 1'b1, 5'd2, 32'd1);
      applyStimulus("blt", 1, itype(6'h05, 1, 2, 16'h0010), 32'h200, 16'h0002, 3, 0, 0, 0, 0, 0);
      checkOutput("tp_blt_taken", 64'(last_redir_valid), 64'h1);

      applyStimulus("jump", 1, {6'h02, 26'h10}, 32'h4000_0010, 16'h0004, 7, 0, 0, 0, 0, 0);
      checkOutput("tp_jump_pc", 64'(last_redir_pc), 64'h4000_0040);

      snap_pc  = ex_pc;
      snap_rsd = ex_rs_data;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("hold", 1, rtype(5, 7, 9), 32'h300, 16'h0001, 0, 0, 0, 0, 1, 0);
         checkOutput("tp_hold_stall", 64'(last_stall), 64'h1);
         checkOutput("tp_hold_pc", 64'(ex_pc), 64'(snap_pc));
         checkOutput("tp_hold_valid", 64'(ex_valid), 64'h1);
      end
      resetPulse("rst_hold");
      applyStimulus("after_rst", 1, rtype(5, 7, 9), 32'h304, 16'h0001, 0, 0, 0, 0, 0, 0);
      checkOutput("tp_rf_cleared", 64'(ex_rs_data), 64'h0);

      for (int n = 0; n < 1500; n++) begin
         logic [31:0] instr;
         instr = $urandom;
         instr[25:21] = 5'($urandom_range(0, 7));
         instr[20:16] = 5'($urandom_range(0, 7));
         applyStimulus("rand", ($urandom_range(0, 9) != 0), instr, $urandom, 16'($urandom),
                       3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      ex_hold = 1'b0;
      resetPulse("rst_sat");
      for (int i = 0; i < 20; i++) begin
         applyStimulus("sat_lw", 1, itype(6'h23, 0, 9, 16'h0), 32'h400, 16'h0008, 0, 0, 0, 0, 0, 0);
         applyStimulus("sat_use", 1, rtype(0, 9, 3), 32'h404, 16'h0001, 0, 0, 0, 0, 0, 0);
      end
      checkOutput("tp_saturate", 64'(stall_count), 64'(CNT_MAX));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised successor to the combinational instruction-decode phase.
- Contains the register file (with write-through bypass), a branch comparator resolved in decode, and load-use hazard detection.
- Adds a registered ID/EX pipeline register with valid/hold/flush handling and a saturating stall counter.
- Sits between the IF/ID register and the execute stage. Control words come from the external Controller as an opaque bundle.

Parameters:
- DATA_W, 32: register/PC width; must be >= 32.
- REG_ADDR_W, 5: register index width; register count is 2**REG_ADDR_W.
- CTRL_W, 16: width of the control bundle passed through to EX.
- MEMREAD_BIT, 3: index of the MemRead bit within the control bundle.
- STALL_CNT_W, 16: width of the stall counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  instr_in/pc_in hold a real instruction.
- instr_in  in  32  instruction from IF/ID.
- pc_in  in  DATA_W  PC+4 from IF/ID.
- ctrl_in  in  CTRL_W  control bundle from Controller for instr_in.
- br_type  in  3  0 none, 1 beq, 2 bne, 3 blt (signed), 4 bgt (signed), 5 bltz, 6 bgtz, 7 jump.
- wb_we  in  1  writeback enable.
- wb_addr  in  REG_ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_hold  in  1  downstream stall; ID/EX must hold its contents.
- flush_in  in  1  squash the instruction entering ID/EX.
- if_stall  out  1  hold PC and IF/ID this cycle.
- redirect_valid  out  1  branch taken or jump.
- redirect_pc  out  DATA_W  target PC.
- ex_valid  out  1  ID/EX valid.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_pc  out  DATA_W  registered pc_in.
- ex_rs_data  out  DATA_W  registered rs value.
- ex_rt_data  out  DATA_W  registered rt value.
- ex_imm  out  DATA_W  registered sign-extended instr[15:0].
- ex_rs  out  REG_ADDR_W  registered rs field.
- ex_rt  out  REG_ADDR_W  registered rt field.
- ex_rd  out  REG_ADDR_W  registered rd field.
- ex_shamt  out  5  registered instr[10:6].
- ex_funct  out  6  registered instr[5:0].
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Field mapping: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], each zero-extended or truncated to REG_ADDR_W.
- Register file:
  - Reset clears all entries to 0.
  - Write on the rising edge when wb_we and wb_addr != 0. Register 0 always reads 0.
  - Reads are combinational. If wb_we and wb_addr == read address != 0, the read returns wb_data (write-through bypass).
- Load-use hazard:
  - hazard = if_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 0) & (ex_rt == rs | ex_rt == rt).
  - The check is conservative: it ignores whether the instruction actually uses rt.
- if_stall = hazard | ex_hold.
- Comparator:
  - blt/bgt use signed compare of rs vs rt.
  - bltz/bgtz use signed compare of rs vs 0.
- Branch target = pc_in + (sext(imm) << 2), modulo 2**DATA_W.
- Jump target = {pc_in[DATA_W-1:28], instr[25:0], 2'b00}.
- redirect_valid = if_valid & !if_stall & !flush_in & (condition true). redirect_pc is a don't-care when redirect_valid=0.
- ID/EX update on each rising edge, in priority order:
  1. ex_hold: all ex_* outputs unchanged, including ex_valid.
  2. flush_in | hazard | !if_valid: insert a bubble. ex_valid=0, ex_ctrl=0; other fields may load or hold, they are don't-care.
  3. Otherwise load: ex_valid=1, ex_ctrl=ctrl_in, data and fields from the current decode.
- stall_count increments by 1 on each edge where hazard=1 & ex_hold=0, and saturates at all-ones.
- Reset (asynchronous, any cycle including mid-stall) sets:
  - ex_valid, ex_ctrl and all ex_* outputs to 0;
  - stall_count to 0;
  - the register file to 0.
- While Reset is asserted, if_stall and redirect_valid follow their equations with ex_valid=0.
- Simultaneous events:
  - Writeback to rs in the same cycle as decode: the bypassed value is loaded into ID/EX.
  - flush_in with hazard: bubble; the counter still increments.
  - ex_hold with flush_in: hold wins, and flush_in is dropped. The upstream stage must keep flush_in asserted until ex_hold=0.

Test Plan:
- Write r5=0x0000_1234 via wb, then decode add rs=5, rt=0 -> one cycle later ex_rs_data=0x1234, ex_rt_data=0, ex_valid=1.
- Same-cycle wb_we to r7=0xDEAD_BEEF while decoding rs=7 -> ex_rs_data=0xDEADBEEF; write to r0 -> r0 still reads 0.
- Load into ID/EX (ctrl MEMREAD_BIT=1, rt=8), next instruction rs=8:
  - hazard cycle: if_stall=1, bubble (ex_valid=0), stall_count=1;
  - following cycle: the instruction loads normally.
- beq with r1=r2=3, pc_in=0x100, imm=0xFFFF -> redirect_valid=1, redirect_pc=0xFC.
- blt with r1=0xFFFF_FFFF (-1), r2=1 -> taken.
- Jump with pc_in=0x4000_0010, instr[25:0]=0x10 -> redirect_pc=0x4000_0040.
- ex_hold asserted 3 cycles with a new instruction waiting -> ex_* unchanged, if_stall=1.
- Assert Reset mid-hold -> all ex_* and stall_count return to 0 immediately.
